stopwatch_ctrl: RTL
===================

Name: stopwatch_ctrl

Overview:
Controller that sequences the two-digit event counter and 7-segment display path as a start/stop/lap stopwatch. It debounces-free synchronizes two active-low push-buttons, runs a prescaler that gates count enables, and maintains a BCD 00–99 count. It also provides a frozen lap value. Its ones/tens outputs feed the existing 4-bit-to-7-segment decoders for HEX0/HEX1.

Parameters:
DIV, 50000000, clk cycles per count increment (≥2)
DIV_W, 26, prescaler width; must satisfy 2^DIV_W ≥ DIV

Ports:
clk  input  1  system clock, all state on rising edge
clr  input  1  asynchronous active-low reset
btn_ss  input  1  start/stop push-button, active-low, asynchronous to clk
btn_lap  input  1  lap/clear push-button, active-low, asynchronous to clk
ones  output  4  displayed BCD ones digit, 0–9
tens  output  4  displayed BCD tens digit, 0–9
running  output  1  high in RUN or LAP
lap_active  output  1  high in LAP; display is frozen
tick  output  1  one-cycle pulse, the cycle after each count increment
wrap  output  1  one-cycle pulse, the cycle after the 99→00 rollover

Behaviour:
- Reset (clr=0, async, any time, including mid-count or mid-lap):
  - state=IDLE; live count, lap register, prescaler = 0.
  - ones=tens=0; running=lap_active=tick=wrap=0.
  - Synchronizer flops go to 1 (released).
  - Normal operation resumes on the first rising edge after clr=1.
- Button input:
  - Each button passes through a 2-flop synchronizer, then a registered previous-value flop.
  - press pulse = prev & ~sync, i.e. a falling edge detect.
  - An input low sampled at edge k produces the pulse during cycle k+1→k+2; the state changes at edge k+2.
  - Holding a button produces exactly one pulse.
- FSM states: IDLE, RUN, PAUSE, LAP.
  - IDLE: ss → RUN. lap is ignored.
  - RUN: ss → PAUSE. lap → LAP; the lap register captures the live count on that edge.
  - LAP: counting continues. lap → RUN, and the display returns to live. ss → PAUSE, and the display returns to live.
  - PAUSE: ss → RUN. lap → IDLE; the live count and prescaler clear to 0 on that edge.
  - Same-cycle ss and lap pulses: ss wins and lap is discarded in every state.
- Prescaler:
  - Counts 0..DIV-1 only in RUN/LAP.
  - Holds its value in PAUSE, so resume keeps the phase.
  - Cleared in IDLE.
  - On the edge where prescaler==DIV-1 and state is RUN/LAP: prescaler→0, live count increments, and the tick register is set for the next cycle.
  - A count step happens on the edge leaving LAP/RUN only if the prescaler was already at DIV-1; the state change does not suppress it.
- Count:
  - BCD, ones 0–9, carry into tens 0–9.
  - 09→10; 99→00, with the wrap register set for one cycle alongside tick.
  - The count never holds a non-BCD value.
- Outputs:
  - ones/tens = lap register when state==LAP, else the live count. They are registered state, not combinationally decoded from buttons.
  - running/lap_active are decoded from the state register.

Test Plan (DIV=4):
1. Reset mid-run: in RUN with count 37, drive clr=0 between edges → ones=tens=0, running=0 immediately, without waiting for clk. Release clr, run 20 cycles with no buttons → stays 00, IDLE.
2. Start/latency: btn_ss low for 5 cycles from IDLE → running=1 exactly 2 edges after the sampling edge, with one state change only. After 4 more edges, first tick; count=01. After 40 cycles in RUN, count=10 and 10 tick pulses have occurred.
3. Wrap: preload by running to 99, then next prescaler wrap → ones=tens=0, tick=1 and wrap=1 for exactly one cycle, running stays 1.
4. Lap: at count 15 press lap → display holds 15 while the live count advances to 23 over 32 cycles; lap_active=1. Press lap again → display shows 23 (live), lap_active=0.
5. Pause/clear: pause at prescaler phase 2, count 42; wait 50 cycles → display 42, no ticks. Resume → first tick after 2 edges. Pause, then lap → 00, state IDLE, prescaler 0.
6. Simultaneous: in RUN assert both buttons on the same sample edge → PAUSE, lap_active stays 0, lap register unchanged.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Start/stop/lap stopwatch sequencer for the two-digit BCD event counter and
// its 7-segment display path. Two active-low push-buttons are synchronized
// and edge-detected (no debounce). A prescaler divides clk down to count
// steps. The live count runs 00..99 in BCD. A lap register holds a frozen
// copy of the count for display while counting continues underneath.
//
// Parameters
//   DIV    clk cycles per count increment (>= 2)
//   DIV_W  prescaler width, 2**DIV_W >= DIV
//
// Ports
//   clk         system clock, all state changes on the rising edge
//   clr         asynchronous active-low reset
//   btn_ss      start/stop button, active-low, asynchronous to clk
//   btn_lap     lap/clear button, active-low, asynchronous to clk
//   ones        displayed BCD ones digit (lap value in LAP, else live)
//   tens        displayed BCD tens digit (lap value in LAP, else live)
//   running     high in RUN or LAP
//   lap_active  high in LAP, display frozen
//   tick        one-cycle pulse in the cycle after each count increment
//   wrap        one-cycle pulse in the cycle after the 99 -> 00 rollover
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
   parameter int unsigned DIV   = 50000000,
   parameter int unsigned DIV_W = 26
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       btn_ss,
   input  logic       btn_lap,
   output logic [3:0] ones,
   output logic [3:0] tens,
   output logic       running,
   output logic       lap_active,
   output logic       tick,
   output logic       wrap
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      LAP   = 2'd3
   } state_t;

   localparam logic [DIV_W-1:0] PRE_LAST = DIV_W'(DIV - 1);

   // ---------------------------------------------------------------------------
   // Button synchronizers and falling-edge detectors
   // ---------------------------------------------------------------------------
   logic ss_meta, ss_sync, ss_prev;
   logic lap_meta, lap_sync, lap_prev;

   // NOTE: the synchronizer chain resets to 1 (button released) so that
   // leaving reset never looks like a press.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         ss_meta  <= 1'b1;
         ss_sync  <= 1'b1;
         ss_prev  <= 1'b1;
         lap_meta <= 1'b1;
         lap_sync <= 1'b1;
         lap_prev <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments make every flop sample the value
         // from before the edge, which is what builds a real shift chain.
         ss_meta  <= btn_ss;
         ss_sync  <= ss_meta;
         ss_prev  <= ss_sync;
         lap_meta <= btn_lap;
         lap_sync <= lap_meta;
         lap_prev <= lap_sync;
      end
   end

   logic ss_press;
   logic lap_press;
   logic lap_go;

   assign ss_press  = ss_prev & ~ss_sync;
   assign lap_press = lap_prev & ~lap_sync;
   // Start/stop has priority: a lap press in the same cycle is dropped.
   assign lap_go    = lap_press & ~ss_press;

   // ---------------------------------------------------------------------------
   // BCD increment: returns {rollover, tens, ones}
   // ---------------------------------------------------------------------------
   function automatic logic [8:0] bcd_inc(input logic [3:0] t, input logic [3:0] o);
      logic [8:0] r;
      if (o != 4'd9)
         r = {1'b0, t, o + 4'd1};
      else if (t != 4'd9)
         r = {1'b0, t + 4'd1, 4'd0};
      else
         r = {1'b1, 4'd0, 4'd0};
      return r;
   endfunction

   // ---------------------------------------------------------------------------
   // State, prescaler, live count, lap register, pulse outputs
   // ---------------------------------------------------------------------------
   state_t           state;
   logic [DIV_W-1:0] pre;
   logic [3:0]       live_ones, live_tens;
   logic [3:0]       lap_ones, lap_tens;
   logic             counting;

   assign counting = (state == RUN) || (state == LAP);

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state     <= IDLE;
         pre       <= '0;
         live_ones <= 4'd0;
         live_tens <= 4'd0;
         lap_ones  <= 4'd0;
         lap_tens  <= 4'd0;
         tick      <= 1'b0;
         wrap      <= 1'b0;
      end else begin
         tick <= 1'b0;
         wrap <= 1'b0;

         // Counting depends on the current state only, so a step due on the
         // edge that leaves RUN/LAP still happens.
         if (counting) begin
            if (pre == PRE_LAST) begin
               pre <= '0;
               {wrap, live_tens, live_ones} <= bcd_inc(live_tens, live_ones);
               tick <= 1'b1;
            end else begin
               pre <= pre + 1'b1;
            end
         end else if (state == IDLE) begin
            pre <= '0;
         end
         // PAUSE: prescaler holds so resuming keeps the phase.

         case (state)
            IDLE: begin
               if (ss_press)
                  state <= RUN;
            end
            RUN: begin
               if (ss_press) begin
                  state <= PAUSE;
               end else if (lap_go) begin
                  state    <= LAP;
                  lap_ones <= live_ones;
                  lap_tens <= live_tens;
               end
            end
            LAP: begin
               if (ss_press)
                  state <= PAUSE;
               else if (lap_go)
                  state <= RUN;
            end
            PAUSE: begin
               if (ss_press) begin
                  state <= RUN;
               end else if (lap_go) begin
                  state     <= IDLE;
                  pre       <= '0;
                  live_ones <= 4'd0;
                  live_tens <= 4'd0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs: selected from registers only
   // ---------------------------------------------------------------------------
   assign ones       = (state == LAP) ? lap_ones : live_ones;
   assign tens       = (state == LAP) ? lap_tens : live_tens;
   assign running    = counting;
   assign lap_active = (state == LAP);

   // Digits never leave the BCD range, and a rollover always comes with a tick.
   a_live_bcd: assert property (@(posedge clk) disable iff (!clr)
      (live_ones <= 4'd9) && (live_tens <= 4'd9));
   a_wrap_tick: assert property (@(posedge clk) disable iff (!clr)
      wrap |-> tick);

endmodule
